// File: rtl/trito_meros.sv
// trito_meros: push-button driven scroller showing a 4-character window of
// the hex string "0123456789ABCDEF" on a multiplexed 4-digit 7-segment
// display. The button is synchronized, debounced and edge-detected. Each
// accepted press advances the window by one character.
module trito_meros #(
    parameter int DEB_CYCLES = 16
) (
    input  logic enable,
    input  logic reset,
    input  logic clk,
    output logic an3,
    output logic an2,
    output logic an1,
    output logic an0,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic e,
    output logic f,
    output logic g,
    output logic dp
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;
    logic             press_q, press_d;
    logic [3:0]       p_q, p_d;
    logic [3:0]       r_q, r_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;

    // Active-low segment pattern {a,b,c,d,e,f,g} for one hex character.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Button conditioning: synchronizer, run-length debounce and press edge.
    always_comb begin
        sync1_d = enable;
        sync2_d = sync1_q;

        // Count consecutive high samples; saturate so a long hold cannot wrap.
        if (!sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        // Level rises once the run is long enough, drops on the first low sample.
        deb_d   = sync2_q & (deb_q | (cnt_d == CNT_MAX));
        press_d = deb_d & ~deb_q;
        p_d     = p_q + {3'b000, press_q};
    end

    // Display refresh: next anode pattern and segment load for the next R.
    always_comb begin
        r_d  = r_q + 4'd1;
        an_d = 4'b1111;
        if (r_d[1:0] != 2'b00) begin
            case (r_d[3:2])
                2'b00:   an_d = 4'b0111;
                2'b01:   an_d = 4'b1011;
                2'b10:   an_d = 4'b1101;
                default: an_d = 4'b1110;
            endcase
        end
        // Segments only change entering or leaving a blanking slot, never
        // while a digit is lit; the reload leaving blanking also covers the
        // first digit after reset.
        seg_d = seg_q;
        if ((r_d[1:0] == 2'b00) || (r_q[1:0] == 2'b00)) begin
            seg_d = seg_decode(p_d + {2'b00, r_d[3:2]});
        end
    end

    // State registers; reset blanks the display and drops any press in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            deb_q   <= 1'b0;
            press_q <= 1'b0;
            p_q     <= 4'h0;
            r_q     <= 4'h0;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            press_q <= press_d;
            p_q     <= p_d;
            r_q     <= r_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign {an3, an2, an1, an0}   = an_q;
    assign {a, b, c, d, e, f, g}  = seg_q;
    assign dp                     = 1'b1;

endmodule

// File: tb/tb_trito_meros.sv
// Testbench for trito_meros: directed scenarios plus randomized press
// sequences, checked against a reference model of the scrolling display.
module tb_trito_meros;

    logic enable, reset, clk;
    logic an3, an2, an1, an0, a, b, c, d, e, f, g, dp;

    trito_meros #(.DEB_CYCLES(16)) dut (
        .enable(enable), .reset(reset), .clk(clk),
        .an3(an3), .an2(an2), .an1(an1), .an0(an0),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Lit segments of each character, as letters.
    string lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [6:0] model_seg(input int v);
        logic [6:0] s;
        string t;
        s = 7'b1111111;
        t = lit[v % 16];
        for (int i = 0; i < t.len(); i++) s[6 - (int'(t[i]) - 97)] = 1'b0;
        return s;
    endfunction

    // Model state
    int   exp_p  = 0;
    logic seg_on = 1'b0;
    int   cyc;
    int   incs   = 0;
    logic [3:0] prev_p;

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Continuous display check: refresh phase from cycles since reset release.
    always @(negedge clk) begin
        int r;
        logic [3:0] exp_an;
        if (reset) begin
            r = cyc % 16;
            exp_an = 4'b1111;
            if ((r % 4) != 0) exp_an[3 - (r / 4)] = 1'b0;
            check_eq("anodes", {28'd0, an3, an2, an1, an0}, {28'd0, exp_an});
            check_eq("dp", {31'd0, dp}, 32'd1);
            if (seg_on && (r % 4) != 0)
                check_eq("segments", {25'd0, a, b, c, d, e, f, g}, {25'd0, model_seg(exp_p + r / 4)});
        end
    end

    // Count position increments observed while out of reset.
    always @(negedge clk) begin
        if (!reset) begin
            prev_p = 4'h0;
        end else begin
            if (dut.p_q == prev_p + 4'd1) incs++;
            prev_p = dut.p_q;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One button episode: high for hi cycles, then low for gap cycles.
    task automatic press(input int hi, input int gap);
        enable = 1'b1;
        tick(hi);
        enable = 1'b0;
        tick(gap);
    endtask

    task automatic settle_and_show(input int p);
        exp_p  = p;
        seg_on = 1'b1;
        tick(32);
        seg_on = 1'b0;
    endtask

    initial begin
        int lat;
        enable = 1'b0;
        reset  = 1'b0;
        tick(2);
        #1;
        // Reset state
        check_eq("reset_anodes", {28'd0, an3, an2, an1, an0}, 32'hF);
        check_eq("reset_segs", {25'd0, a, b, c, d, e, f, g}, 32'h7F);
        check_eq("reset_dp", {31'd0, dp}, 32'd1);
        check_eq("reset_p", {28'd0, dut.p_q}, 32'd0);
        reset = 1'b1;
        seg_on = 1'b1;
        exp_p = 0;
        tick(1);
        check_eq("an3_shows_0", {25'd0, a, b, c, d, e, f, g}, 32'b0000001);
        tick(12);
        check_eq("an0_low", {31'd0, an0}, 32'd0);
        check_eq("an0_shows_3", {25'd0, a, b, c, d, e, f, g}, 32'b0000110);
        tick(19);
        seg_on = 1'b0;

        // Single press with latency bound
        incs = 0;
        enable = 1'b1;
        lat = 26;
        for (int i = 1; i <= 25; i++) begin
            tick(1);
            if (dut.p_q == 4'd1) begin
                lat = i;
                break;
            end
        end
        check_eq("press_latency_le_20", {31'd0, lat <= 20}, 32'd1);
        if (lat < 20) tick(20 - lat);
        enable = 1'b0;
        tick(30);
        check_eq("single_press_incs", incs, 1);
        check_eq("single_press_p", {28'd0, dut.p_q}, 1);
        settle_and_show(1);

        // Glitch rejection
        incs = 0;
        press(5, 40);
        check_eq("glitch_incs", incs, 0);
        check_eq("glitch_p", {28'd0, dut.p_q}, 1);

        // Long hold gives a single step
        press(300, 40);
        check_eq("hold_incs", incs, 1);
        check_eq("hold_p", {28'd0, dut.p_q}, 2);
        settle_and_show(2);

        // Wrap: return to 0 first, then 16 presses
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        incs = 0;
        for (int k = 1; k <= 16; k++) begin
            press(40, 310);
            check_eq("wrap_p", {28'd0, dut.p_q}, k % 16);
            if (k == 14) begin
                settle_and_show(14);
                check_eq("wrap_E_model_an1", {25'd0, model_seg(14 + 2)}, {25'd0, 7'b0000001});
            end
        end
        check_eq("wrap_incs", incs, 16);
        settle_and_show(0);

        // Mid-press reset at debounce count 10
        press(60, 40);
        incs = 0;
        enable = 1'b1;
        tick(12);
        check_eq("midreset_cnt", {27'd0, dut.cnt_q}, 10);
        reset = 1'b0;
        enable = 1'b0;
        #1;
        check_eq("midreset_p", {28'd0, dut.p_q}, 0);
        check_eq("midreset_anodes", {28'd0, an3, an2, an1, an0}, 32'hF);
        tick(2);
        reset = 1'b1;
        tick(40);
        check_eq("midreset_incs", incs, 0);
        check_eq("midreset_p_after", {28'd0, dut.p_q}, 0);
        settle_and_show(0);

        // Randomized press episodes
        for (int k = 0; k < 30; k++) begin
            int hi;
            if ($urandom_range(0, 2) == 0) hi = $urandom_range(1, 10);
            else                           hi = $urandom_range(25, 300);
            press(hi, $urandom_range(10, 40));
            if (hi >= 25) exp_p = (exp_p + 1) % 16;
            tick(20);
            check_eq("rand_p", {28'd0, dut.p_q}, exp_p);
            if ((k % 5) == 0) settle_and_show(exp_p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/trito_meros.md
TRITO_MEROS -- requirements
Module: trito_meros

Interface
REQ-001 SHALL use the port order: enable, reset, clk, an3, an2, an1, an0, a, b, c, d, e, f, g, dp.
REQ-002 SHALL provide `clk`, input, 1 bit: the single system clock; all state SHALL change on its rising edge.
REQ-003 SHALL provide `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL provide `enable`, input, 1 bit: raw, asynchronous push-button; a press advances the display.
REQ-005 SHALL provide `an3`, `an2`, `an1`, `an0`, outputs, 1 bit each: digit anodes, active-low; an3 is the leftmost digit.
REQ-006 SHALL provide `a`, `b`, `c`, `d`, `e`, `f`, `g`, outputs, 1 bit each: shared cathode segments, active-low (0 = lit).
REQ-007 SHALL provide `dp`, output, 1 bit: decimal point, active-low, held at 1 (off) at all times.
REQ-008 SHALL define the parameter DEB_CYCLES, default 16: consecutive high samples needed to accept a press.

Function
REQ-009 SHALL pass `enable` through a 2-flop synchronizer before any other use.
REQ-010 SHALL count consecutive high cycles of the synchronized input; any low sample SHALL clear the count.
REQ-011 SHALL set the debounced level to 1 when the count reaches DEB_CYCLES, and to 0 on the first low synchronized sample.
REQ-012 SHALL create a one-cycle press pulse on each 0->1 edge of the debounced level; holding the button SHALL NOT repeat the pulse.
REQ-013 SHALL keep a 4-bit position register P that increments by 1 on the clock edge after the press pulse.
REQ-014 SHALL wrap P from 4'hF to 4'h0.
REQ-015 SHALL show a 4-character window of the hex message "0123456789ABCDEF": an3 shows P, an2 shows P+1, an1 shows P+2, an0 shows P+3, all mod 16.
REQ-016 SHALL keep a free-running 4-bit refresh counter R.
REQ-017 SHALL select the digit by R[3:2]: 00 selects an3, 01 selects an2, 10 selects an1, 11 selects an0.
REQ-018 SHALL drive the selected anode low only when R[1:0] != 00; the 00 phase is a blanking cycle with all anodes high, to prevent ghosting.
REQ-019 SHALL load the segments for the next digit during its blanking cycle, so the segments are stable whenever an anode is low.
REQ-020 SHALL drive registered anodes and segments, with exactly one anode low at any time outside blanking.
REQ-021 SHALL decode the lit segments as:
- 0 = abcdef; 1 = bc; 2 = abdeg; 3 = abcdg
- 4 = bcfg; 5 = acdfg; 6 = acdefg; 7 = abc
- 8 = abcdefg; 9 = abcdfg; A = abcefg; b = cdefg
- C = adef; d = bcdeg; E = adefg; F = aefg
REQ-022 SHALL accept no press while the debounced level is still high from a previous press; a new press requires the debounced level to return low first.

Reset
REQ-023 SHALL, while `reset` = 0, force P = 0, R = 0, the synchronizer, debounce count and debounced level to 0, an3..an0 = 1111, a..g = 1111111 and dp = 1.
REQ-024 SHALL resume refresh from R = 0 on the first clock edge after `reset` returns to 1.
REQ-025 SHALL discard any press in progress when reset is asserted mid-press.

Verification
REQ-026 SHALL be checked for reset: assert reset low for 2 cycles -> all anodes and segments are 1; after release, the an3 phase shows 0 (a..g = 0000001), an0 shows 3 (0000110), and dp = 1 throughout.
REQ-027 SHALL be checked for a single press: enable high for 20 cycles -> P becomes 1 exactly once, within 20 cycles of the rise; an3 shows 1 and an0 shows 4.
REQ-028 SHALL be checked for glitch rejection: enable high for 5 cycles, then low -> P unchanged.
REQ-029 SHALL be checked for hold: enable high for 300 cycles -> exactly one increment.
REQ-030 SHALL be checked for wrap: 16 valid presses spaced 350 cycles apart -> P steps 1..F, then 0; at P = E the digits read E, F, 0, 1.
REQ-031 SHALL be checked for mid-press reset: reset asserted at debounce count 10 -> P = 0 and no increment after release.
